// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Constants shared by the SPI master and the companion spi_slave:
//   - default transfer width and clock divider
//   - SPI mode constants (mode 0: CPOL=0, CPHA=0)
//   - master FSM state encoding
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_DEF_WIDTH   = 8;
   localparam int SPI_DEF_CLK_DIV = 4;

   // Mode 0: clock idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// Half-period timer for the SPI master. While en is high it emits a one-cycle
// tick every CLK_DIV clk cycles; the first tick arrives CLK_DIV cycles after
// en rises. While en is low the counter is held at its reload value.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   en    in  run the timer
//   tick  out one-cycle pulse at the end of each half-period
// -----------------------------------------------------------------------------
module spi_tick_gen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int            CW     = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = RELOAD;
      if (en) begin
         cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en & (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 SPI master, MSB first. One transfer per accepted start:
//   SETUP (cs low, clock low) -> SHIFT (WIDTH clock periods, each high then
//   low) -> HOLD (clock low) -> GAP (cs high) -> IDLE.
// Every half-period is CLK_DIV clk cycles, timed by spi_tick_gen.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   start, tx_data  transfer request (sampled only in IDLE) and word to send
//   rx_data         last received word, updated together with done
//   busy, done      not-idle flag, one-cycle completion pulse
//   spi_clk, mosi,  SPI bus; cs is active low
//   miso, cs
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = SPI_DEF_CLK_DIV,
   parameter int WIDTH   = SPI_DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             done,
   output logic             spi_clk,
   output logic             mosi,
   input  logic             miso,
   output logic             cs
);

   localparam int            BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   spi_state_e       state_q, state_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             tail_q, tail_d;
   logic             spi_clk_q, spi_clk_d;
   logic             cs_q, cs_d;
   logic             mosi_q, mosi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tick;

   spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (state_q != ST_IDLE),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      bit_cnt_d = bit_cnt_q;
      tail_d    = tail_q;
      spi_clk_d = spi_clk_q;
      cs_d      = cs_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SETUP;
               tx_sh_d   = tx_data;
               rx_sh_d   = '0;
               bit_cnt_d = '0;
               tail_d    = 1'b0;
               cs_d      = 1'b0;
               mosi_d    = tx_data[WIDTH-1];
            end
         end
         ST_SETUP: begin
            // First rising edge: sample miso as the clock goes high.
            if (tick) begin
               state_d   = ST_SHIFT;
               spi_clk_d = 1'b1;
               rx_sh_d   = (rx_sh_q << 1) | WIDTH'(miso);
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               if (spi_clk_q) begin
                  // Falling edge: advance mosi unless this was the last bit.
                  spi_clk_d = 1'b0;
                  if (bit_cnt_q == LAST) begin
                     tail_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                     tx_sh_d   = tx_sh_q << 1;
                     mosi_d    = tx_sh_d[WIDTH-1];
                  end
               end else if (tail_q) begin
                  // Low half of the final period has elapsed.
                  state_d = ST_HOLD;
               end else begin
                  spi_clk_d = 1'b1;
                  rx_sh_d   = (rx_sh_q << 1) | WIDTH'(miso);
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d   = ST_GAP;
               cs_d      = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sh_q;
               done_d    = 1'b1;
            end
         end
         ST_GAP: begin
            if (tick) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cs_d      = 1'b1;
            mosi_d    = 1'b0;
            spi_clk_d = SPI_CPOL;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         bit_cnt_q <= '0;
         tail_q    <= 1'b0;
         spi_clk_q <= SPI_CPOL;
         cs_q      <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         bit_cnt_q <= bit_cnt_d;
         tail_q    <= tail_d;
         spi_clk_q <= spi_clk_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign rx_data = rx_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign spi_clk = spi_clk_q;
   assign mosi    = mosi_q;
   assign cs      = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Self-checking bench for spi_master (CLK_DIV=4, WIDTH=8). miso comes from a
// selectable source: loopback of mosi, constant 1, or a mode-0 slave model.
// A negedge monitor records cs/spi_clk edges, the bits seen on mosi at each
// rising spi_clk edge (the slave's received word) and done pulses.
// -----------------------------------------------------------------------------
module tb_spi_master;

   localparam int CLK_DIV = 4;
   localparam int WIDTH   = 8;
   localparam int XFER    = CLK_DIV * (2 * WIDTH + 2);

   localparam int SEL_LOOP  = 0;
   localparam int SEL_ONES  = 1;
   localparam int SEL_SLAVE = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic [WIDTH-1:0] rx_data;
   logic             busy;
   logic             done;
   logic             spi_clk;
   logic             mosi;
   logic             miso;
   logic             cs;

   always #5 clk = ~clk;

   spi_master #(
      .CLK_DIV (CLK_DIV),
      .WIDTH   (WIDTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .busy    (busy),
      .done    (done),
      .spi_clk (spi_clk),
      .mosi    (mosi),
      .miso    (miso),
      .cs      (cs)
   );

   int checks = 0;
   int errors = 0;

   // miso source and slave model state
   int               sel = SEL_LOOP;
   logic [WIDTH-1:0] slave_word = '0;
   logic [WIDTH-1:0] slave_tx = '0;

   always_comb begin
      miso = 1'b0;
      case (sel)
         SEL_LOOP:  miso = mosi;
         SEL_ONES:  miso = 1'b1;
         default:   miso = slave_tx[WIDTH-1];
      endcase
   end

   // monitor
   int               cyc = 0;
   int               fall_cyc = 0;
   int               rise_cyc = 0;
   int               last_gap = 0;
   int               rises = 0;
   int               done_cnt = 0;
   int               mosi_bad = 0;
   logic [WIDTH-1:0] cap = '0;
   logic             prev_cs = 1'b1;
   logic             prev_sclk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_cs   <= cs;
      prev_sclk <= spi_clk;
      if (!cs && prev_cs) begin
         fall_cyc <= cyc;
         last_gap <= cyc - rise_cyc;
         rises    <= 0;
         cap      <= '0;
         slave_tx <= slave_word;
      end else begin
         if (!cs && spi_clk && !prev_sclk) begin
            rises <= rises + 1;
            cap   <= {cap[WIDTH-2:0], mosi};
         end
         if (!spi_clk && prev_sclk) begin
            slave_tx <= slave_tx << 1;
         end
      end
      if (cs && !prev_cs) rise_cyc <= cyc;
      if (done) done_cnt <= done_cnt + 1;
      if (cs && mosi) mosi_bad <= mosi_bad + 1;
   end

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
      end
   endtask

   // Expected received word from the rules of each miso source.
   function automatic logic [WIDTH-1:0] model_rx(input int s, input logic [WIDTH-1:0] tx,
                                                 input logic [WIDTH-1:0] sw);
      case (s)
         SEL_LOOP: return tx;
         SEL_ONES: return {WIDTH{1'b1}};
         default:  return sw;
      endcase
   endfunction

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_done(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("done_timeout", done_cnt, target);
   endtask

   task automatic run_xfer(input string nm, input logic [WIDTH-1:0] tx, input int s,
                           input logic [WIDTH-1:0] sw, input logic [WIDTH-1:0] exp_rx);
      int d0, b0, st;
      wait_idle();
      @(negedge clk);
      sel        = s;
      slave_word = sw;
      d0         = done_cnt;
      b0         = mosi_bad;
      tx_data    = tx;
      start      = 1'b1;
      st         = cyc;
      @(negedge clk);
      start   = 1'b0;
      tx_data = ~tx;
      wait_done(d0 + 1);
      wait_idle();
      repeat (2) @(negedge clk);
      chk({nm, "_rx_data"}, rx_data, exp_rx);
      chk({nm, "_slave_rx"}, cap, tx);
      chk({nm, "_sclk_rises"}, rises, WIDTH);
      chk({nm, "_cs_fall_lat"}, fall_cyc - st, 1);
      chk({nm, "_cs_low_len"}, rise_cyc - fall_cyc, XFER);
      chk({nm, "_done_pulses"}, done_cnt - d0, 1);
      chk({nm, "_mosi_cs_high"}, mosi_bad - b0, 0);
      $display("xfer %s tx=%02h sel=%0d sw=%02h rx=%02h exp=%02h", nm, tx, s, sw, rx_data, exp_rx);
   endtask

   typedef struct {
      logic [WIDTH-1:0] tx;
      int               s;
      logic [WIDTH-1:0] sw;
      logic [WIDTH-1:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int d0;
      vecs[0] = '{tx: 8'hA5, s: SEL_LOOP,  sw: 8'h00, exp_rx: 8'hA5};
      vecs[1] = '{tx: 8'h00, s: SEL_ONES,  sw: 8'h00, exp_rx: 8'hFF};
      vecs[2] = '{tx: 8'h2C, s: SEL_SLAVE, sw: 8'h5A, exp_rx: 8'h5A};
      vecs[3] = '{tx: 8'hFF, s: SEL_LOOP,  sw: 8'h00, exp_rx: 8'hFF};
      vecs[4] = '{tx: 8'h01, s: SEL_SLAVE, sw: 8'h80, exp_rx: 8'h80};

      // reset state
      reset   = 1'b1;
      start   = 1'b0;
      tx_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", cs, 1);
      chk("rst_spi_clk", spi_clk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rx_data", rx_data, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven transfers
      foreach (vecs[i]) begin
         run_xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].s, vecs[i].sw, vecs[i].exp_rx);
      end

      // randomized transfers against the model
      for (int i = 0; i < 12; i++) begin
         logic [WIDTH-1:0] tx, sw;
         int               s;
         tx = WIDTH'($urandom);
         sw = WIDTH'($urandom);
         s  = int'($urandom_range(0, 2));
         run_xfer($sformatf("rnd%0d", i), tx, s, sw, model_rx(s, tx, sw));
      end

      // start held high, tx_data changed mid-transfer
      wait_idle();
      @(negedge clk);
      sel     = SEL_LOOP;
      d0      = done_cnt;
      tx_data = 8'h3C;
      start   = 1'b1;
      repeat (10) @(negedge clk);
      tx_data = 8'hC3;
      wait_done(d0 + 1);
      chk("hold_first_rx", rx_data, 8'h3C);
      chk("hold_first_mosi", cap, 8'h3C);
      begin
         bit ok = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!cs) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) chk("hold_restart_timeout", 0, 1);
      end
      start = 1'b0;
      @(negedge clk);
      chk("hold_gap_ge_clkdiv", (last_gap >= CLK_DIV) ? 1 : 0, 1);
      wait_done(d0 + 2);
      wait_idle();
      repeat (2) @(negedge clk);
      chk("hold_second_rx", rx_data, 8'hC3);
      chk("hold_done_pulses", done_cnt - d0, 2);
      $display("xfer hold_start rx=%02h gap=%0d", rx_data, last_gap);

      // reset mid-transfer
      wait_idle();
      @(negedge clk);
      sel     = SEL_LOOP;
      tx_data = 8'h81;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("midrst_pre_sclk", spi_clk, 1);
      chk("midrst_pre_cs", cs, 0);
      #1 reset = 1'b1;
      #1;
      chk("midrst_cs", cs, 1);
      chk("midrst_spi_clk", spi_clk, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mosi", mosi, 0);
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_rx_data", rx_data, 0);
      chk("midrst_idle_cs", cs, 1);
      $display("xfer mid_reset rx=%02h cs=%0b", rx_data, cs);

      // block recovers after the aborted transfer
      run_xfer("post_rst", 8'h6E, SEL_LOOP, 8'h00, 8'h6E);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
